// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: hazard-controller state encodings and default widths
package riscv_ctrl_pkg;
  localparam int XLEN_DEF = 32;
  localparam int CNT_W_DEF = 16;
  typedef enum logic [1:0] {RUN = 2'd0, REDIRECT = 2'd1, BUBBLE = 2'd2, HOLD = 2'd3} ctrl_state_e;
endpackage

// File: rtl/branch_hazard_ctrl_if.sv
// branch_hazard_ctrl_if: pipeline <-> hazard-controller signal bundle
interface branch_hazard_ctrl_if
  import riscv_ctrl_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int CNT_W = CNT_W_DEF
);
  logic Branch_mem;
  logic [XLEN-1:0] branch_target_mem;
  logic load_use_hazard_id;
  logic mem_busy;
  logic pc_write;
  logic pc_src;
  logic [XLEN-1:0] pc_target;
  logic if_id_write;
  logic if_id_flush;
  logic id_ex_flush;
  logic ex_mem_flush;
  logic [1:0] ctrl_state;
  logic [CNT_W-1:0] flush_cnt;
  logic [CNT_W-1:0] bubble_cnt;
  modport master (
    output Branch_mem, branch_target_mem, load_use_hazard_id, mem_busy,
    input pc_write, pc_src, pc_target, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush,
    input ctrl_state, flush_cnt, bubble_cnt
  );
  modport slave (
    input Branch_mem, branch_target_mem, load_use_hazard_id, mem_busy,
    output pc_write, pc_src, pc_target, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush,
    output ctrl_state, flush_cnt, bubble_cnt
  );
endinterface

// File: rtl/sat_counter.sv
// sat_counter: event counter that sticks at all-ones
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (inc && !(&cnt)) cnt <= cnt + 1'b1;
endmodule

// File: rtl/branch_hazard_ctrl.sv
// branch_hazard_ctrl: Moore FSM for branch redirect, load-use bubble and memory freeze
// FLUSH_STATS_EN adds saturating redirect/bubble entry counters.
module branch_hazard_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic clk,
  input logic rst_n,
  branch_hazard_ctrl_if.slave bus
);
  ctrl_state_e state, nxt, resume, nxt_resume;
  logic [XLEN-1:0] target;
  logic capture;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= RUN;
      resume <= RUN;
      target <= '0;
    end else begin
      state <= nxt;
      resume <= nxt_resume;
      if (capture) target <= bus.branch_target_mem;
    end
  // a freeze wins everywhere; branches seen while frozen are left for the resolver to replay
  always_comb begin
    nxt = state;
    nxt_resume = resume;
    capture = 1'b0;
    if (bus.mem_busy) begin
      nxt = HOLD;
      nxt_resume = (state == HOLD) ? resume : state;
    end else begin
      case (state)
        RUN: begin
          capture = bus.Branch_mem;
          nxt = bus.Branch_mem ? REDIRECT : bus.load_use_hazard_id ? BUBBLE : RUN;
        end
        HOLD: nxt = resume;
        default: nxt = RUN;
      endcase
    end
  end
  always_comb begin
    bus.pc_write = (state == RUN) || (state == REDIRECT);
    bus.if_id_write = (state == RUN) || (state == REDIRECT);
    bus.pc_src = state == REDIRECT;
    bus.if_id_flush = state == REDIRECT;
    bus.ex_mem_flush = state == REDIRECT;
    bus.id_ex_flush = (state == REDIRECT) || (state == BUBBLE);
    bus.ctrl_state = state;
    bus.pc_target = target;
  end
`ifdef FLUSH_STATS_EN
  sat_counter #(.W(CNT_W)) u_flush_cnt (.clk(clk), .rst_n(rst_n), .inc(nxt == REDIRECT), .cnt(bus.flush_cnt));
  sat_counter #(.W(CNT_W)) u_bubble_cnt (.clk(clk), .rst_n(rst_n), .inc(nxt == BUBBLE), .cnt(bus.bubble_cnt));
`else
  assign bus.flush_cnt = '0;
  assign bus.bubble_cnt = '0;
`endif
endmodule

// File: doc/branch_hazard_ctrl.md
BRANCH_HAZARD_CTRL -- requirements
Module: branch_hazard_ctrl

Interface
REQ-001 Parameter XLEN, default 32, width of the PC and branch target.
REQ-002 Parameter CNT_W, default 16, width of the statistics counters.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Branch_mem  input  1  taken-branch decision from the MEM-stage branch resolver.
REQ-006 branch_target_mem  input  XLEN  branch target PC, valid when Branch_mem=1.
REQ-007 load_use_hazard_id  input  1  ID-stage instruction depends on a load currently in EX.
REQ-008 mem_busy  input  1  data memory not ready; the pipeline must freeze.
REQ-009 pc_write  output  1  PC register enable.
REQ-010 pc_src  output  1  0 selects PC+4; 1 selects pc_target.
REQ-011 pc_target  output  XLEN  registered redirect PC.
REQ-012 if_id_write  output  1  IF/ID register enable.
REQ-013 if_id_flush, id_ex_flush, ex_mem_flush  output  1 each  pipeline-register clear.
REQ-014 ctrl_state  output  2  current FSM state encoding.
REQ-015 flush_cnt, bubble_cnt  output  CNT_W each  event statistics.

Function
REQ-016 The FSM SHALL have four states: RUN=0, REDIRECT=1, BUBBLE=2, HOLD=3.
REQ-017 All outputs except the counters SHALL be decoded from the registered state only (Moore).
REQ-018 RUN SHALL drive pc_write=1, if_id_write=1, pc_src=0 and all flushes=0.
REQ-019 In RUN, mem_busy=1 SHALL take priority over Branch_mem, and Branch_mem over load_use_hazard_id, when selecting the next state.
REQ-020 From RUN, Branch_mem=1 with mem_busy=0 SHALL capture branch_target_mem into pc_target and move to REDIRECT.
REQ-021 REDIRECT SHALL last exactly one cycle and drive pc_write=1, pc_src=1, if_id_write=1, if_id_flush=1, id_ex_flush=1, ex_mem_flush=1, then return to RUN.
REQ-022 In REDIRECT, Branch_mem and load_use_hazard_id SHALL be ignored, because they belong to squashed instructions.
REQ-023 From RUN, load_use_hazard_id=1 with Branch_mem=0 and mem_busy=0 SHALL move to BUBBLE.
REQ-024 BUBBLE SHALL last one cycle and drive pc_write=0, if_id_write=0, id_ex_flush=1, with other flushes 0, then return to RUN.
REQ-025 mem_busy=1 in any state SHALL move to HOLD and record the interrupted state as the resume state.
REQ-026 HOLD SHALL drive pc_write=0, if_id_write=0, all flushes=0, and stay while mem_busy=1.
REQ-027 On exit from HOLD, the FSM SHALL enter the resume state.
REQ-028 A branch arriving during HOLD SHALL NOT be captured; the resolver re-presents it after the freeze.
REQ-029 pc_target SHALL change only on capture in RUN and SHALL hold its value otherwise.

Reset
REQ-030 While rst_n=0, the block SHALL hold state=RUN, resume state=RUN, pc_target=0 and counters=0.
REQ-031 During reset, outputs SHALL take RUN values: pc_write=1, if_id_write=1, pc_src=0, flushes=0.
REQ-032 Reset asserted in REDIRECT, BUBBLE or HOLD SHALL abort that state immediately, with no redirect or bubble emitted afterwards.

Configuration
REQ-033 With FLUSH_STATS_EN defined, flush_cnt SHALL increment on each entry to REDIRECT.
REQ-034 With FLUSH_STATS_EN defined, bubble_cnt SHALL increment on each entry to BUBBLE.
REQ-035 With FLUSH_STATS_EN defined, both counters SHALL saturate at 2^CNT_W-1.
REQ-036 Without FLUSH_STATS_EN, flush_cnt and bubble_cnt SHALL be constant 0 and no counter flops SHALL be generated.

Structure
REQ-037 Package riscv_ctrl_pkg SHALL hold the state encodings RUN/REDIRECT/BUBBLE/HOLD and the default XLEN and CNT_W.
REQ-038 The saturating counter SHALL be sub-module sat_counter, instantiated twice under FLUSH_STATS_EN.

Verification
REQ-039 Reset then idle: pc_write=1, pc_src=0, ctrl_state=0, pc_target=0.
REQ-040 Branch_mem=1 with target 0x0000_0040 for one cycle -> next cycle REDIRECT: pc_src=1, pc_target=0x40, all three flushes=1; RUN the cycle after.
REQ-041 load_use_hazard_id=1 for one cycle -> one BUBBLE cycle with pc_write=0, if_id_write=0, id_ex_flush=1; bubble_cnt=1 if FLUSH_STATS_EN.
REQ-042 Branch_mem=1 and load_use_hazard_id=1 in the same cycle -> REDIRECT only, with no BUBBLE; flush_cnt=1, bubble_cnt=0.
REQ-043 Branch accepted, then mem_busy=1 for 3 cycles starting in REDIRECT -> HOLD for 3 cycles, then a single REDIRECT cycle with pc_target unchanged.
REQ-044 Force flush_cnt to 0xFFFF and issue another branch -> flush_cnt stays 0xFFFF.
